// File: rtl/rom_stream_reader.sv
// rom_stream_reader: reads a window of a 1-cycle-latency synchronous rom
// and re-emits the words as a valid/ready stream through a credit FIFO.
// Ports: clk, rst (async, active high); start/start_addr/length launch a
// transfer; busy/done report progress; rom_en/rom_addr/rom_data talk to
// the rom; out_data/out_valid/out_ready/out_last form the stream.
// Define RSR_CHECKSUM_EN to add the checksum output (XOR of popped words).
module rom_stream_reader #(
  parameter int DATA_WIDTH = 4,
  parameter int ADDR_WIDTH = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [ADDR_WIDTH:0]   length,
  output logic                  busy,
  output logic                  done,
  output logic                  rom_en,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_data,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last
`ifdef RSR_CHECKSUM_EN
  ,
  output logic [DATA_WIDTH-1:0] checksum
`endif
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW+1:0] DEP = (PW+2)'(FIFO_DEPTH);
  localparam logic [ADDR_WIDTH:0] LONE = 1;
  localparam logic [ADDR_WIDTH:0] LZERO = 0;
  localparam logic [ADDR_WIDTH-1:0] AONE = 1;
  localparam logic [PW-1:0] PONE = 1;
  localparam logic [PW:0] CONE = 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  state_t state;

  logic [ADDR_WIDTH:0] len_r;
  logic [ADDR_WIDTH:0] iss_cnt;
  logic [ADDR_WIDTH:0] iss_nxt;
  logic                last0;
  logic                cap_v;
  logic                cap_last;

  logic [DATA_WIDTH:0] mem [FIFO_DEPTH];
  logic [PW-1:0]       wp;
  logic [PW-1:0]       rp;
  logic [PW:0]         cnt;

  logic [1:0]    infl;
  logic [PW+1:0] used;
  logic          credit;
  logic          pop;
  logic          wr;

  // rom_en is stage 0 of the read pipeline, cap_v is stage 1
  assign infl    = {1'b0, rom_en} + {1'b0, cap_v};
  assign used    = {1'b0, cnt} + {{PW{1'b0}}, infl};
  assign credit  = used < DEP;
  assign iss_nxt = iss_cnt + LONE;

  assign out_valid = cnt != '0;
  assign out_data  = mem[rp][DATA_WIDTH-1:0];
  assign out_last  = out_valid & mem[rp][DATA_WIDTH];
  assign pop       = out_valid & out_ready;
  assign wr        = cap_v;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      rom_en   <= 1'b0;
      rom_addr <= '0;
      len_r    <= '0;
      iss_cnt  <= '0;
      last0    <= 1'b0;
    end else begin
      done   <= 1'b0;
      rom_en <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            if (length == LZERO) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              // first read issues on the accepting edge
              busy     <= 1'b1;
              len_r    <= length;
              rom_en   <= 1'b1;
              rom_addr <= start_addr;
              iss_cnt  <= LONE;
              last0    <= length == LONE;
              state    <= (length == LONE) ? DRAIN : RUN;
            end
          end
        end
        RUN: begin
          if (credit) begin
            rom_en   <= 1'b1;
            rom_addr <= rom_addr + AONE;
            iss_cnt  <= iss_nxt;
            last0    <= iss_nxt == len_r;
            if (iss_nxt == len_r) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (pop && out_last) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // valid/last travel alongside the rom read; data only taken when valid
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap_v    <= 1'b0;
      cap_last <= 1'b0;
    end else begin
      cap_v    <= rom_en;
      cap_last <= last0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (wr) begin
        mem[wp] <= {cap_last, rom_data};
        wp      <= wp + PONE;
      end
      if (pop) rp <= rp + PONE;
      unique case ({wr, pop})
        2'b10:   cnt <= cnt + CONE;
        2'b01:   cnt <= cnt - CONE;
        default: cnt <= cnt;
      endcase
    end
  end

`ifdef RSR_CHECKSUM_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      checksum <= '0;
    end else if (state == IDLE && start) begin
      checksum <= '0;
    end else if (pop) begin
      checksum <= checksum ^ out_data;
    end
  end
`endif

endmodule
